// File: rtl/mul_div_if.sv
// Request / writeback bundle for the multi-cycle multiply/divide unit.
//
// Handshake: the requester raises start for one cycle with op/src_a/src_b/dest
// valid; the unit accepts it on that edge only if it is idle (busy==0) and
// flush is low. Starts seen while busy are dropped, not queued. Completion is
// a one-cycle done pulse with wb_dest/wb_data/div_by_zero valid in the same
// cycle; there is no backpressure on the writeback side. flush aborts any
// in-flight operation on the edge it is sampled.
interface mul_div_if #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 3
);
  logic                  start;
  logic                  flush;
  logic [1:0]            op;
  logic [WIDTH-1:0]      src_a;
  logic [WIDTH-1:0]      src_b;
  logic [REG_ADDR_W-1:0] dest;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic [WIDTH-1:0]      wb_data;
  logic                  dbg_state;

  modport master (
    output start, flush, op, src_a, src_b, dest,
    input  busy, done, div_by_zero, wb_en, wb_dest, wb_data, dbg_state
  );

  modport slave (
    input  start, flush, op, src_a, src_b, dest,
    output busy, done, div_by_zero, wb_en, wb_dest, wb_data, dbg_state
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit, one result bit per clock.
// A shared {hi, lo} register pair serves both operations:
//   multiply: lo starts as the multiplier, hi accumulates; shift right each step.
//   divide:   lo starts as the dividend and collects quotient bits, hi is the
//             partial remainder; shift left each step (restoring division).
// op[0] selects the hi half of the final pair, which is MULH or REMU.
module mul_div_unit #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 3,
  parameter int ITER       = 16
) (
  input  logic     clk,
  input  logic     rst,
  mul_div_if.slave bus
);

  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_op;
  logic [WIDTH-1:0]      r_m;     // multiplicand for MUL*, divisor for DIV*
  logic [WIDTH-1:0]      r_hi;
  logic [WIDTH-1:0]      r_lo;
  logic [REG_ADDR_W-1:0] r_dest;

  logic                  r_busy;
  logic                  r_done;
  logic                  r_dbz;
  logic                  r_wb_en;
  logic [REG_ADDR_W-1:0] r_wb_dest;
  logic [WIDTH-1:0]      r_wb_data;

  logic [WIDTH:0]        w_mul_sum;
  logic [WIDTH:0]        w_div_shift;
  logic                  w_div_ge;
  logic [WIDTH-1:0]      w_div_diff;
  logic [WIDTH-1:0]      w_next_hi;
  logic [WIDTH-1:0]      w_next_lo;
  logic [WIDTH-1:0]      w_result;
  logic                  w_div_zero;

  // One iteration step for either operation, plus the result selection.
  // A zero divisor needs no special case: every trial subtract succeeds, so
  // the quotient fills with ones and the dividend shifts through into hi.
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_m});
    w_div_diff  = w_div_shift[WIDTH-1:0] - r_m;
    if (r_op[1]) begin
      w_next_hi = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
      w_next_lo = {r_lo[WIDTH-2:0], w_div_ge};
    end else begin
      w_next_hi = w_mul_sum[WIDTH:1];
      w_next_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
    w_result   = r_op[0] ? w_next_hi : w_next_lo;
    w_div_zero = r_op[1] && (r_m == '0);
  end

  // Control FSM, datapath registers and registered writeback outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_m       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dest    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_dest <= '0;
      r_wb_data <= '0;
    end else begin
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_wb_en <= 1'b0;
      if (bus.flush) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_op    <= bus.op;
              r_m     <= bus.op[1] ? bus.src_b : bus.src_a;
              r_lo    <= bus.op[1] ? bus.src_a : bus.src_b;
              r_hi    <= '0;
              r_dest  <= bus.dest;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
          end
          S_RUN: begin
            r_hi  <= w_next_hi;
            r_lo  <= w_next_lo;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_ITER) begin
              r_cnt     <= '0;
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_dbz     <= w_div_zero;
              r_wb_en   <= (r_dest != '0);
              r_wb_dest <= r_dest;
              r_wb_data <= w_result;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.wb_en       = r_wb_en;
  assign bus.wb_dest     = r_wb_dest;
  assign bus.wb_data     = r_wb_data;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed cases, abort paths and randomized ops
// scored against a plain-arithmetic reference model.
module tb_mul_div_unit;

  localparam int WIDTH = 16;
  localparam int AW    = 3;
  localparam int SB_W  = AW + 1 + WIDTH;  // {dest, div_by_zero, data}

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [SB_W-1:0]  exp_q[$];
  logic [WIDTH-1:0] exp_wb_data;
  logic [AW-1:0]    exp_wb_dest;
  logic [WIDTH-1:0] last_data;

  mul_div_if #(.WIDTH(WIDTH), .REG_ADDR_W(AW)) bus ();

  mul_div_unit #(.WIDTH(WIDTH), .REG_ADDR_W(AW), .ITER(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {div_by_zero, data} from the arithmetic definition of each op.
  function automatic logic [WIDTH:0] ref_model(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    case (op)
      2'd0:    return {1'b0, p[WIDTH-1:0]};
      2'd1:    return {1'b0, p[2*WIDTH-1:WIDTH]};
      2'd2:    return (b == '0) ? {1'b1, {WIDTH{1'b1}}} : {1'b0, a / b};
      default: return (b == '0) ? {1'b1, a} : {1'b0, a % b};
    endcase
  endfunction

  // Called at a negedge; leaves off at the negedge of the done cycle.
  // poke_at >= 0 re-pulses start with junk operands while busy.
  task automatic do_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [AW-1:0] d,
                       input int poke_at);
    int busy_cnt;
    int early;
    logic [SB_W-1:0] e;
    bus.op = op; bus.src_a = a; bus.src_b = b; bus.dest = d;
    bus.start = 1'b1;
    exp_q.push_back({d, ref_model(op, a, b)});
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.src_a = WIDTH'($urandom);
    bus.src_b = WIDTH'($urandom);
    bus.dest  = AW'($urandom);
    busy_cnt = 0;
    early    = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done || bus.wb_en) early++;
      bus.start = (i == poke_at);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("busy_len", busy_cnt, 16);
    check("early_done", early, 0);
    check("busy_at_done", bus.busy, 0);
    check("done", bus.done, 1);
    check("sb_depth", exp_q.size(), 1);
    e = exp_q.pop_front();
    check("wb_en", bus.wb_en, 32'(e[SB_W-1:WIDTH+1] != '0));
    check("wb_dest", bus.wb_dest, e[SB_W-1:WIDTH+1]);
    check("div_by_zero", bus.div_by_zero, e[WIDTH]);
    check("wb_data", bus.wb_data, e[WIDTH-1:0]);
    exp_wb_data = e[WIDTH-1:0];
    exp_wb_dest = e[SB_W-1:WIDTH+1];
    last_data   = bus.wb_data;
  endtask

  // One cycle after a done: pulses cleared, writeback fields held.
  task automatic idle_check();
    @(negedge clk);
    check("done_clr", bus.done, 0);
    check("wb_en_clr", bus.wb_en, 0);
    check("dbz_clr", bus.div_by_zero, 0);
    check("busy_idle", bus.busy, 0);
    check("wb_data_hold", bus.wb_data, exp_wb_data);
  endtask

  // n cycles with no activity expected and writeback fields unchanged.
  task automatic quiet(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done || bus.wb_en || bus.busy || bus.div_by_zero) pulses++;
    end
    check({tag, "_pulses"}, pulses, 0);
    check({tag, "_wb_data"}, bus.wb_data, exp_wb_data);
    check({tag, "_wb_dest"}, bus.wb_dest, exp_wb_dest);
  endtask

  // Start an op, then assert flush so it is sampled on edge E(k+1).
  task automatic flush_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [AW-1:0] d,
                          input int k, input string tag);
    bus.op = op; bus.src_a = a; bus.src_b = b; bus.dest = d;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (k) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    quiet(tag, 20);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_wb_data = '0;
    exp_wb_dest = '0;
    last_data   = '0;
    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0;
    bus.src_a = '0; bus.src_b = '0; bus.dest = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    check("rst_wb_en", bus.wb_en, 0);
    check("rst_wb_dest", bus.wb_dest, 0);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_state", bus.dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // directed multiply / divide cases
    do_op(2'd0, 16'd300, 16'd500, 3'd3, -1);
    check("plan_mul", last_data, 16'h49F0);
    idle_check();
    do_op(2'd1, 16'd300, 16'd500, 3'd3, -1);
    check("plan_mulh", last_data, 16'h0002);
    idle_check();
    do_op(2'd2, 16'd1000, 16'd7, 3'd5, -1);
    check("plan_divu", last_data, 16'h008E);
    idle_check();
    do_op(2'd3, 16'd1000, 16'd7, 3'd5, -1);
    check("plan_remu", last_data, 16'h0006);
    idle_check();
    do_op(2'd2, 16'h1234, 16'd0, 3'd4, -1);
    check("plan_div0_q", last_data, 16'hFFFF);
    idle_check();
    do_op(2'd3, 16'h1234, 16'd0, 3'd4, -1);
    check("plan_div0_r", last_data, 16'h1234);
    idle_check();
    do_op(2'd0, 16'd2, 16'd3, 3'd0, -1);
    check("plan_r0", last_data, 16'h0006);
    idle_check();

    // ignored start while busy, then a start accepted in the done cycle
    do_op(2'd0, 16'd4, 16'd5, 3'd1, 7);
    check("plan_ignore", last_data, 16'h0014);
    do_op(2'd2, 16'd100, 16'd9, 3'd2, -1);
    check("plan_b2b", last_data, 16'h000B);
    idle_check();

    // abort paths
    flush_op(2'd2, 16'd1000, 16'd7, 3'd5, 9, "flush_mid");
    flush_op(2'd0, 16'd300, 16'd500, 3'd6, 15, "flush_e16");
    bus.op = 2'd0; bus.src_a = 16'd9; bus.src_b = 16'd9; bus.dest = 3'd7;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("start_flush_state", bus.dbg_state, 0);
    quiet("start_flush", 20);

    // reset in the middle of a run
    bus.op = 2'd0; bus.src_a = 16'd77; bus.src_b = 16'd3; bus.dest = 3'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_wb_data", bus.wb_data, 0);
    check("rst_mid_wb_dest", bus.wb_dest, 0);
    check("rst_mid_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_wb_data = '0;
    exp_wb_dest = '0;
    quiet("rst_mid", 20);

    // randomized operations, mostly back-to-back
    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) rb = WIDTH'($urandom_range(1, 15));
      do_op(2'($urandom_range(0, 3)), ra, rb, AW'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1);
      if ($urandom_range(0, 2) == 0) idle_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
